pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline sequencing controller for the 5-stage `cpu` core. It generates the PC and IF/ID enables and the per-stage flush (bubble-insert) strobes. It resolves three events: load-use stalls detected in ID, control redirects resolved in MEM, and orderly halt when the halt word (0xFFFFFFFF) is decoded. It sits beside the IF_ID/ID_EX/EX_MEM registers and replaces the free-running behaviour of the current pipeline.

## Interface
Parameters:
- `HALT_WORD`, 32'hFFFF_FFFF: instruction encoding that terminates execution.
- `DRAIN_CYCLES`, 3: edges for the halt word to travel ID→WB.
- `CNT_W`, 32: width of performance counters.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `id_instr`  in  32  instruction in IF/ID.
- `id_rs`, `id_rt`  in  5 each  source register fields of ID instruction.
- `id_uses_rt`  in  1  ID instruction reads rt as a source (R-type, branch, store).
- `ex_mem_read`  in  1  instruction in EX is a load.
- `ex_rt`  in  5  load destination in EX.
- `mem_redirect`  in  1  taken branch or any jump in MEM (Branch&zero | Jump≠0).
- `wb_instr`  in  32  instruction in MEM/WB.
- `pc_en`  out  1  PC load enable.
- `if_id_en`  out  1  IF/ID load enable (0 = hold).
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush`  out  1 each  load NOP into that register at next edge.
- `halted`  out  1  registered, sticky halt indication.
- `halt_err`  out  1  registered; drain ended without HALT_WORD in WB.

## Operation
- FSM states: RUN, DRAIN, HALTED. Reset → RUN.
- Event priority per cycle: redirect > load-use > halt detect.
- Redirect (any state except HALTED, `mem_redirect`=1): `pc_en`=1, `if_id_en`=1, all three flushes=1. In DRAIN: state → RUN, drain counter cleared (halt was wrong-path; the IF/ID flush kills it).
- Load-use (RUN, no redirect): `ex_mem_read` & `ex_rt`≠0 & (`ex_rt`==`id_rs` | (`id_uses_rt` & `ex_rt`==`id_rt`)) → `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1 for that cycle. No state change. Exactly one bubble per load-use, because the bubble clears `ex_mem_read`.
- Halt detect (RUN, no redirect, no load-use, `id_instr`==HALT_WORD): `pc_en`=0, `if_id_en`=0. The halt word advances to ID/EX. State → DRAIN and counter ← DRAIN_CYCLES−1.
- DRAIN: `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1, so only bubbles follow the halt. Counter decrements each cycle. At count 0: state → HALTED, `halted`←1, and `halt_err`←(`wb_instr`≠HALT_WORD), both evaluated on the same edge.
- HALTED: all enables 0, all flushes 0. Pipeline is frozen and inputs are ignored. Exit only via reset.
- Otherwise (RUN, no event): `pc_en`=`if_id_en`=1, flushes=0.
- Counter width: $clog2(DRAIN_CYCLES)+1, never wraps (stops at 0).

## Timing
- Enables and flushes are combinational from state and current inputs. They act at the next rising edge.
- Redirect penalty is 3 cycles. Load-use penalty is 1 cycle.
- `halted` rises DRAIN_CYCLES+1 edges after the cycle in which the halt word is first seen in ID with no higher-priority event.
- While `rst`=0: `pc_en`=0, `if_id_en`=0, all flushes=1, `halted`=0, `halt_err`=0, state RUN, counters 0.
- Reset asserted mid-DRAIN or in HALTED returns to RUN immediately (asynchronous). The first fetch is on the first edge after `rst` rises.

## Configuration
- `PIPE_CTRL_PERF_EN` defined: adds outputs `perf_cycles`, `perf_stalls`, `perf_flushes` (CNT_W each), all reset to 0.
  - `perf_cycles` counts non-reset cycles outside HALTED.
  - `perf_stalls` counts load-use cycles.
  - `perf_flushes` counts redirect cycles.
  - All saturate at all-ones and freeze in HALTED.
- Not defined: ports and counters absent; behaviour otherwise identical.

## Structure
- Shared package `cpu_pkg`: state enum (RUN/DRAIN/HALTED), `HALT_WORD` constant, `NOP_WORD` (32'h0) used by pipeline registers on flush.
- One sub-module, `hazard_detect`: the combinational load-use comparator, which is reusable by a future forwarding unit. FSM and counters stay in `pipe_ctrl`.

## Test plan
- Load-use: `ex_mem_read`=1, `ex_rt`=5, `id_rs`=5 for one cycle → `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1 that cycle only. Same stimulus with `ex_rt`=0 → no stall.
- Redirect with simultaneous load-use: `mem_redirect`=1 while hazard true → all flushes=1, `pc_en`=1, no stall.
- Halt: `id_instr`=FFFFFFFF at cycle N, `wb_instr`=FFFFFFFF at N+3 → DRAIN for cycles N+1..N+3, `halted`=1 after edge N+4, `halt_err`=0. Same with `wb_instr`=0 → `halt_err`=1.
- Wrong-path halt: halt in ID at N, `mem_redirect`=1 at N+1 → state RUN, `if_id_flush`=1, `halted` stays 0.
- Reset in HALTED: drop `rst` asynchronously mid-cycle → `halted`=0 immediately; after release, `pc_en`=1 with no events.
- With `PIPE_CTRL_PERF_EN`: 10 run cycles, 2 stalls, 1 redirect → `perf_cycles`=10, `perf_stalls`=2, `perf_flushes`=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage cpu core: sequencing-FSM state encoding,
// the halt instruction encoding and the NOP loaded by pipeline registers on flush.
package cpu_pkg;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

  typedef logic [1:0] pipe_state_t;

  localparam pipe_state_t ST_RUN    = 2'd0;
  localparam pipe_state_t ST_DRAIN  = 2'd1;
  localparam pipe_state_t ST_HALTED = 2'd2;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: the load in EX writes a register that the ID instruction
// reads. Register 0 never carries a dependency.
module hazard_detect (
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  output logic       load_use
);

  assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: PC/IF-ID enables, per-stage flush strobes,
// load-use stall, MEM redirect and halt drain. Define PIPE_CTRL_PERF_EN for perf counters.
module pipe_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] HALT_WORD    = cpu_pkg::HALT_WORD,
  parameter int          DRAIN_CYCLES = 3,
  parameter int          CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       id_instr,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rt,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_rt,
  input  logic              mem_redirect,
  input  logic [31:0]       wb_instr,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic              halted,
  output logic              halt_err,
`ifdef PIPE_CTRL_PERF_EN
  output logic [CNT_W-1:0]  perf_cycles,
  output logic [CNT_W-1:0]  perf_stalls,
  output logic [CNT_W-1:0]  perf_flushes,
`endif
  output pipe_state_t       dbg_state
);

  localparam int DW = $clog2(DRAIN_CYCLES) + 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(DRAIN_CYCLES - 1);
  localparam logic [DW-1:0] DRAIN_DEC  = DW'(1);

  pipe_state_t   state;
  logic [DW-1:0] drain_cnt;
  logic          load_use;
  logic          redirect_evt;
  logic          stall_evt;
  logic          halt_evt;

  hazard_detect u_hazard_detect (
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .load_use    (load_use)
  );

  // Priority: redirect > load-use > halt detect. Only redirect acts in DRAIN.
  assign redirect_evt = mem_redirect && (state != ST_HALTED);
  assign stall_evt    = (state == ST_RUN) && !mem_redirect && load_use;
  assign halt_evt     = (state == ST_RUN) && !mem_redirect && !load_use &&
                        (id_instr == HALT_WORD);

  assign dbg_state = state;

  always_comb begin
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (!rst) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (redirect_evt) begin
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else begin
      case (state)
        ST_RUN: begin
          if (stall_evt) begin
            id_ex_flush = 1'b1;
          end else if (!halt_evt) begin
            pc_en    = 1'b1;
            if_id_en = 1'b1;
          end
        end
        // Hold IF/ID and feed bubbles behind the halt word.
        ST_DRAIN: id_ex_flush = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
      halted    <= 1'b0;
      halt_err  <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (halt_evt) begin
            state     <= ST_DRAIN;
            drain_cnt <= DRAIN_INIT;
          end
        end
        ST_DRAIN: begin
          // A redirect means the halt was fetched down the wrong path.
          if (mem_redirect) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
          end else if (drain_cnt == '0) begin
            state    <= ST_HALTED;
            halted   <= 1'b1;
            halt_err <= (wb_instr != HALT_WORD);
          end else begin
            drain_cnt <= drain_cnt - DRAIN_DEC;
          end
        end
        ST_HALTED: ;
        default: state <= ST_RUN;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_INC = CNT_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cycles  <= '0;
      perf_stalls  <= '0;
      perf_flushes <= '0;
    end else if (state != ST_HALTED) begin
      if (perf_cycles != CNT_MAX) perf_cycles <= perf_cycles + CNT_INC;
      if (stall_evt && (perf_stalls != CNT_MAX)) perf_stalls <= perf_stalls + CNT_INC;
      if (redirect_evt && (perf_flushes != CNT_MAX)) perf_flushes <= perf_flushes + CNT_INC;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus randomized traffic checked against
// a cycle-indexed reference model (halt timing measured as cycles since acceptance).
module tb_pipe_ctrl;
  import cpu_pkg::*;

  localparam logic [31:0] HW = 32'hFFFF_FFFF;
  localparam int DC = 3;
  localparam int CNT_W = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] id_instr = '0;
  logic [4:0]  id_rs = '0;
  logic [4:0]  id_rt = '0;
  logic        id_uses_rt = 1'b0;
  logic        ex_mem_read = 1'b0;
  logic [4:0]  ex_rt = '0;
  logic        mem_redirect = 1'b0;
  logic [31:0] wb_instr = '0;
  logic        pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush;
  logic        halted, halt_err;
  logic [1:0]  dbg_state;
`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] perf_cycles, perf_stalls, perf_flushes;
`endif

  pipe_ctrl #(.HALT_WORD(HW), .DRAIN_CYCLES(DC), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_instr     (id_instr),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .mem_redirect (mem_redirect),
    .wb_instr     (wb_instr),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_flush (ex_mem_flush),
    .halted       (halted),
    .halt_err     (halt_err),
`ifdef PIPE_CTRL_PERF_EN
    .perf_cycles  (perf_cycles),
    .perf_stalls  (perf_stalls),
    .perf_flushes (perf_flushes),
`endif
    .dbg_state    (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard and reference model
  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] exp_q[$];

  int cyc = 0;
  int halt_at = -1;
  bit m_halted = 1'b0;
  bit m_herr = 1'b0;
  int m_cycles = 0;
  int m_stalls = 0;
  int m_flushes = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_lu();
    return ex_mem_read && (ex_rt != 5'd0) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

  // Expected {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush}
  function automatic logic [4:0] model_ctl();
    if (m_halted) return 5'b00000;
    if (mem_redirect) return 5'b11111;
    if (halt_at >= 0) return 5'b00010;
    if (model_lu()) return 5'b00010;
    if (id_instr == HW) return 5'b00000;
    return 5'b11000;
  endfunction

  function automatic logic [1:0] model_state();
    if (m_halted) return ST_HALTED;
    if (halt_at >= 0) return ST_DRAIN;
    return ST_RUN;
  endfunction

  task automatic model_update();
    bit lu;
    lu = model_lu();
    if (!m_halted) begin
      m_cycles++;
      if (mem_redirect) m_flushes++;
      else if (halt_at < 0 && lu) m_stalls++;
    end
    if (!m_halted) begin
      if (halt_at >= 0) begin
        if (mem_redirect) halt_at = -1;
        else if (cyc == halt_at + DC) begin
          m_halted = 1'b1;
          m_herr = (wb_instr != HW);
          halt_at = -1;
        end
      end else if (!mem_redirect && !lu && id_instr == HW) begin
        halt_at = cyc;
      end
    end
    cyc++;
    exp_q.push_back({m_halted, m_herr});
  endtask

  // Drivers
  task automatic set_in(input logic [31:0] instr, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urt, input logic mr, input logic [4:0] ert,
                        input logic redir, input logic [31:0] wb);
    id_instr = instr; id_rs = rs; id_rt = rt; id_uses_rt = urt;
    ex_mem_read = mr; ex_rt = ert; mem_redirect = redir; wb_instr = wb;
  endtask

  task automatic drive_random();
    id_rs = 5'($urandom_range(0, 31));
    id_rt = 5'($urandom_range(0, 31));
    id_uses_rt = 1'($urandom_range(0, 1));
    ex_mem_read = ($urandom_range(0, 2) == 0);
    case ($urandom_range(0, 3))
      0: ex_rt = id_rs;
      1: ex_rt = id_rt;
      2: ex_rt = 5'd0;
      default: ex_rt = 5'($urandom_range(0, 31));
    endcase
    mem_redirect = ($urandom_range(0, 9) == 0);
    id_instr = ($urandom_range(0, 15) == 0) ? HW : $urandom();
    wb_instr = ($urandom_range(0, 1) == 1) ? HW : $urandom();
  endtask

  // One cycle: compare at negedge, advance model at posedge, return at posedge+1.
  task automatic step();
    @(negedge clk);
    check_eq("ctl", {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush}, model_ctl());
    check_eq("state", dbg_state, model_state());
    if (exp_q.size() > 0) check_eq("halt_flags", {halted, halt_err}, exp_q.pop_front());
    @(posedge clk);
    model_update();
    #1;
  endtask

  // Asynchronous reset dropped mid-cycle, released just after an edge.
  task automatic reset_dut();
    #2 rst = 1'b0;
    #1;
    check_eq("rst_ctl", {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush}, 5'b00111);
    check_eq("rst_halted", halted, 1'b0);
    check_eq("rst_herr", halt_err, 1'b0);
    check_eq("rst_state", dbg_state, ST_RUN);
`ifdef PIPE_CTRL_PERF_EN
    check_eq("rst_perf", perf_cycles | perf_stalls | perf_flushes, 32'd0);
`endif
    cyc = 0; halt_at = -1; m_halted = 1'b0; m_herr = 1'b0;
    m_cycles = 0; m_stalls = 0; m_flushes = 0;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.push_back(2'b00);
  endtask

  initial begin
    reset_dut();

    // Idle run
    set_in(32'h0, 0, 0, 0, 0, 0, 0, 0);
    #1 check_eq("idle_pc", pc_en, 1'b1);
    step();

    // Load-use via rs, then one bubble only
    set_in(32'h1234, 5, 0, 0, 1, 5, 0, 0);
    #1 check_eq("lu_rs", {pc_en, if_id_en, id_ex_flush}, 3'b001);
    step();
    set_in(32'h1234, 5, 0, 0, 0, 5, 0, 0);
    step();
    // ex_rt = 0 never stalls
    set_in(32'h1234, 0, 0, 0, 1, 0, 0, 0);
    #1 check_eq("lu_r0", pc_en, 1'b1);
    step();
    // rt dependency only when id_uses_rt
    set_in(32'h1234, 3, 7, 1, 1, 7, 0, 0);
    step();
    set_in(32'h1234, 3, 7, 0, 1, 7, 0, 0);
    step();

    // Redirect beats load-use
    set_in(32'h1234, 5, 0, 0, 1, 5, 1, 0);
    #1 check_eq("redir_lu", {pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush}, 5'b11111);
    step();

    // Halt with HALT_WORD reaching WB
    set_in(HW, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    step();
    set_in(HW, 0, 0, 0, 0, 0, 0, HW);
    check_eq("halt_pre", halted, 1'b0);
    step();
    check_eq("halt_done", halted, 1'b1);
    check_eq("halt_ok", halt_err, 1'b0);
    set_in(HW, 5, 5, 1, 1, 5, 1, 0);
    step();
    reset_dut();
    set_in(32'h0, 0, 0, 0, 0, 0, 0, 0);
    #1 check_eq("post_rst_pc", pc_en, 1'b1);
    step();

    // Halt with wrong word in WB
    set_in(HW, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    step();
    step();
    check_eq("herr_done", halted, 1'b1);
    check_eq("herr_set", halt_err, 1'b1);
    reset_dut();

    // Wrong-path halt cancelled by redirect
    set_in(HW, 0, 0, 0, 0, 0, 0, 0);
    step();
    set_in(HW, 0, 0, 0, 0, 0, 1, 0);
    #1 check_eq("wp_iff", if_id_flush, 1'b1);
    step();
    check_eq("wp_state", dbg_state, ST_RUN);
    set_in(32'h0, 0, 0, 0, 0, 0, 0, HW);
    for (int i = 0; i < 5; i++) step();
    check_eq("wp_halted", halted, 1'b0);

`ifdef PIPE_CTRL_PERF_EN
    // 10 cycles: 2 load-use, 1 redirect
    reset_dut();
    for (int i = 0; i < 10; i++) begin
      case (i)
        1, 5: set_in(32'h0, 5, 0, 0, 1, 5, 0, 0);
        3: set_in(32'h0, 0, 0, 0, 0, 0, 1, 0);
        default: set_in(32'h0, 0, 0, 0, 0, 0, 0, 0);
      endcase
      step();
    end
    check_eq("perf_cycles", perf_cycles, 32'd10);
    check_eq("perf_stalls", perf_stalls, 32'd2);
    check_eq("perf_flushes", perf_flushes, 32'd1);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive_random();
      step();
      if (m_halted && $urandom_range(0, 3) == 0) reset_dut();
      else if ($urandom_range(0, 199) == 0) reset_dut();
    end
`ifdef PIPE_CTRL_PERF_EN
    check_eq("perf_cycles_rand", perf_cycles, m_cycles);
    check_eq("perf_stalls_rand", perf_stalls, m_stalls);
    check_eq("perf_flushes_rand", perf_flushes, m_flushes);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
